// File: rtl/regfile_dbg_port_if.sv
// regfile_dbg_port_if
//   Bundles every signal of the register-file debug engine except clk/reset.
//   master : the engine view (drives status, dump stream, din_ready, rf ports)
//   slave  : the environment view (host control, stream sink/source, regfile)
//   Groups: control  start/mode/first_reg/last_reg/abort -> busy/done/err
//           dump     dout_valid/dout_ready/dout_data/dout_addr/dout_last
//           load     din_valid/din_ready/din_data
//           regfile  rf_ra/rf_rd (comb read), rf_we/rf_wa/rf_wd (edge write)
interface regfile_dbg_port_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          start;
  logic          mode;
  logic [AW-1:0] first_reg;
  logic [AW-1:0] last_reg;
  logic          abort;
  logic          busy;
  logic          done;
  logic          err;
  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] dout_data;
  logic [AW-1:0] dout_addr;
  logic          dout_last;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] din_data;
  logic [AW-1:0] rf_ra;
  logic [DW-1:0] rf_rd;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;

  modport master (
    input  start, mode, first_reg, last_reg, abort,
    output busy, done, err,
    output dout_valid, dout_data, dout_addr, dout_last,
    input  dout_ready,
    input  din_valid, din_data,
    output din_ready,
    output rf_ra, rf_we, rf_wa, rf_wd,
    input  rf_rd
  );

  modport slave (
    output start, mode, first_reg, last_reg, abort,
    input  busy, done, err,
    input  dout_valid, dout_data, dout_addr, dout_last,
    output dout_ready,
    output din_valid, din_data,
    input  din_ready,
    input  rf_ra, rf_we, rf_wa, rf_wd,
    output rf_rd
  );
endinterface

// File: rtl/regfile_dbg_port.sv
// regfile_dbg_port
//   Debug access engine beside the 3-port register file. Dumps a register
//   range out as a valid/ready stream, or loads a range from an input stream.
//   busy is the core stall request.
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    regfile_dbg_port_if.master (control, dump stream, load stream,
//          regfile read/write ports)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; range and mode captured on start
// DUMP_RD  | rf_ra=ptr, register read data captured into the dout regs
// DUMP_OUT | beat presented on dout, held until dout_ready
// LOAD     | one din word per cycle written to rf[ptr] (r0 write dropped)
// DONE     | one-cycle done pulse, err if bad range or abort
module regfile_dbg_port #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                reset,
  regfile_dbg_port_if.master  bus
);

  typedef enum logic [2:0] {IDLE, DUMP_RD, DUMP_OUT, LOAD, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [AW-1:0] last, last_nxt;
  logic          err_q, err_nxt;
  logic          cap;
  logic [DW-1:0] dout_data_q;
  logic [AW-1:0] dout_addr_q;
  logic          dout_last_q;
  logic          load_xfer;

  // The range-end compare happens before any increment, so last=31 never
  // wraps ptr back to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      last        <= '0;
      err_q       <= 1'b0;
      dout_data_q <= '0;
      dout_addr_q <= '0;
      dout_last_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      last  <= last_nxt;
      err_q <= err_nxt;
      if (cap) begin
        dout_data_q <= bus.rf_rd;
        dout_addr_q <= ptr;
        dout_last_q <= (ptr == last);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    last_nxt  = last;
    err_nxt   = err_q;
    cap       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          ptr_nxt  = bus.first_reg;
          last_nxt = bus.last_reg;
          if (bus.first_reg > bus.last_reg) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = bus.mode ? LOAD : DUMP_RD;
            err_nxt   = 1'b0;
          end
        end
      end
      DUMP_RD: begin
        if (bus.abort) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else begin
          cap       = 1'b1;
          state_nxt = DUMP_OUT;
        end
      end
      DUMP_OUT: begin
        // abort wins over a simultaneous handshake: the beat is not counted
        if (bus.abort) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else if (bus.dout_ready) begin
          if (ptr == last) begin
            state_nxt = DONE;
          end else begin
            ptr_nxt   = ptr + AW'(1);
            state_nxt = DUMP_RD;
          end
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else if (bus.din_valid) begin
          if (ptr == last) begin
            state_nxt = DONE;
          end else begin
            ptr_nxt = ptr + AW'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign load_xfer = (state == LOAD) && bus.din_valid && !bus.abort;

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.err        = (state == DONE) && err_q;
  assign bus.dout_valid = (state == DUMP_OUT);
  assign bus.dout_data  = dout_data_q;
  assign bus.dout_addr  = dout_addr_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.din_ready  = (state == LOAD);
  assign bus.rf_ra      = ptr;
  // r0 is hardwired; the word is still consumed so the stream stays aligned
  assign bus.rf_we      = load_xfer && (ptr != '0);
  assign bus.rf_wa      = ptr;
  assign bus.rf_wd      = bus.din_data;

endmodule

// File: tb/tb_regfile_dbg_port.sv
module tb_regfile_dbg_port;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;

  regfile_dbg_port_if #(.AW(AW), .DW(DW)) bus();
  regfile_dbg_port #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // register file model: comb read, r0 reads zero, write on rising edge
  logic [DW-1:0] mem [32];
  logic          pre_we;
  logic [AW-1:0] pre_wa;
  logic [DW-1:0] pre_wd;
  assign bus.rf_rd = (bus.rf_ra == '0) ? '0 : mem[bus.rf_ra];
  always @(posedge clk) begin
    if (bus.rf_we) mem[bus.rf_wa] <= bus.rf_wd;
    else if (pre_we) mem[pre_wa] <= pre_wd;
  end

  // reference contents as the debug engine should leave them
  logic [DW-1:0] ref_rf [32];

  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data; logic last;} beat_t;
  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  beat_t exp_beat[$];
  wr_t   exp_wr[$];
  bit    exp_done[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_ev_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int ready_cyc_cnt = 0;
  bit    hold_pend;
  beat_t hold_val;
  beat_t cur_beat;
  beat_t mon_beat;
  wr_t   mon_wr;
  bit    mon_err;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: pops expectations whenever the DUT presents something
  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      cur_beat = {bus.dout_addr, bus.dout_data, bus.dout_last};
      if (hold_pend && bus.dout_valid) chk("dump_hold_stable", 64'(cur_beat), 64'(hold_val));
      hold_pend = bus.dout_valid && !bus.dout_ready;
      hold_val  = cur_beat;
      if (bus.dout_valid && bus.dout_ready && !bus.abort) begin
        last_ev_cyc = cyc;
        if (exp_beat.size() == 0) chk("dump_unexpected_beat", 64'(cur_beat), 64'd0);
        else begin
          mon_beat = exp_beat.pop_front();
          chk("dump_beat", 64'(cur_beat), 64'(mon_beat));
        end
      end
      if (bus.din_ready) ready_cyc_cnt++;
      if (bus.din_valid && bus.din_ready && !bus.abort) last_ev_cyc = cyc;
      if (bus.rf_we) begin
        if (exp_wr.size() == 0) chk("rf_unexpected_write", 64'({bus.rf_wa, bus.rf_wd}), 64'd0);
        else begin
          mon_wr = exp_wr.pop_front();
          chk("rf_write", 64'({bus.rf_wa, bus.rf_wd}), 64'(mon_wr));
        end
      end
      if (bus.done) begin
        done_cyc = cyc;
        done_cnt++;
        if (exp_done.size() == 0) chk("unexpected_done", 64'(bus.done), 64'd0);
        else begin
          mon_err = exp_done.pop_front();
          chk("done_err", 64'(bus.err), 64'(mon_err));
        end
      end
      if (bus.err && !bus.done) chk("err_without_done", 64'(bus.err), 64'd0);
    end
  end

  task automatic wait_done(input int done_before);
    int guard = 0;
    while (done_cnt == done_before && guard < 600) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  task automatic end_op(input int done_before);
    chk("done_pulse_count", 64'(done_cnt - done_before), 64'd1);
    @(posedge clk); #1;
    chk("busy_after_done", 64'(bus.busy), 64'd0);
    chk("beats_outstanding", 64'(exp_beat.size()), 64'd0);
    chk("writes_outstanding", 64'(exp_wr.size()), 64'd0);
    chk("done_outstanding", 64'(exp_done.size()), 64'd0);
    exp_beat.delete(); exp_wr.delete(); exp_done.delete();
  endtask

  // ready_mode: 0 always ready, 1 random, 2 hold off 5 cycles on beat first+1
  task automatic run_op(input bit md, input int f, input int l, input int abort_at,
                        input int ready_mode, input bit gaps, input logic [DW-1:0] base,
                        input logic [DW-1:0] step, input bit chk_lat);
    logic [DW-1:0] words[$];
    int  done_before, start_cyc, n, k, guard, stall;
    bit  bad;
    bad = (f > l);
    n = l - f + 1;
    done_before = done_cnt;
    if (bad) exp_done.push_back(1'b1);
    else if (!md) begin
      for (int a = f; a <= l; a++) exp_beat.push_back({AW'(a), ref_rf[a], (a == l)});
      exp_done.push_back(1'b0);
    end else begin
      for (int i = 0; i < n; i++) words.push_back((step == '0) ? DW'($urandom) : base + DW'(i) * step);
      for (int i = 0; i < n; i++) begin
        if (abort_at >= 0 && i >= abort_at) break;
        if (f + i != 0) begin
          exp_wr.push_back({AW'(f + i), words[i]});
          ref_rf[f + i] = words[i];
        end
      end
      exp_done.push_back(abort_at >= 0);
    end
    bus.start = 1'b1; bus.mode = md; bus.first_reg = AW'(f); bus.last_reg = AW'(l);
    start_cyc = cyc;
    ready_cyc_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.mode = 1'($urandom); bus.first_reg = AW'($urandom); bus.last_reg = AW'($urandom);
    if (md && !bad) begin
      bus.dout_ready = 1'b1;
      k = 0; guard = 0;
      while (k < n && guard < 400) begin
        if (gaps && $urandom_range(0, 2) == 0) bus.din_valid = 1'b0;
        else begin
          bus.din_valid = 1'b1;
          bus.din_data = words[k];
          bus.abort = (k == abort_at);
        end
        @(posedge clk); #1;
        guard++;
        if (bus.din_valid) k = bus.abort ? n : k + 1;
        bus.din_valid = 1'b0; bus.abort = 1'b0; bus.din_data = DW'($urandom);
      end
    end else if (!md && !bad) begin
      guard = 0; stall = 0;
      while (done_cnt == done_before && guard < 600) begin
        case (ready_mode)
          0: bus.dout_ready = 1'b1;
          1: bus.dout_ready = 1'($urandom_range(0, 1));
          default: begin
            if (bus.dout_valid && bus.dout_addr == AW'(f + 1) && stall < 5) begin
              bus.dout_ready = 1'b0;
              stall++;
            end else bus.dout_ready = 1'b1;
          end
        endcase
        @(posedge clk); #1;
        guard++;
      end
      if (ready_mode == 2) chk("stall_cycles", 64'(stall), 64'd5);
      bus.dout_ready = 1'b1;
    end
    wait_done(done_before);
    if (chk_lat) begin
      if (bad) chk("bad_range_latency", 64'(done_cyc - start_cyc), 64'd1);
      else chk("done_latency", 64'(done_cyc - last_ev_cyc), 64'd1);
    end
    if (md && !bad && !gaps && abort_at < 0) chk("load_cycles", 64'(ready_cyc_cnt), 64'(n));
    end_op(done_before);
  endtask

  int f_r, l_r, ab_r, db;
  bit md_r;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0; bus.first_reg = '0; bus.last_reg = '0; bus.abort = 1'b0;
    bus.dout_ready = 1'b0; bus.din_valid = 1'b0; bus.din_data = '0;
    pre_we = 1'b0; pre_wa = '0; pre_wd = '0;
    hold_pend = 1'b0;
    for (int a = 0; a < 32; a++) ref_rf[a] = '0;
    repeat (2) @(posedge clk); #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_err", 64'(bus.err), 64'd0);
    chk("reset_dout_valid", 64'(bus.dout_valid), 64'd0);
    chk("reset_din_ready", 64'(bus.din_ready), 64'd0);
    chk("reset_rf_we", 64'(bus.rf_we), 64'd0);
    chk("reset_rf_ra", 64'(bus.rf_ra), 64'd0);
    chk("reset_dout_data", 64'(bus.dout_data), 64'd0);
    for (int a = 1; a < 32; a++) begin
      pre_we = 1'b1; pre_wa = AW'(a);
      pre_wd = (a <= 3) ? DW'(a * 32'h11) : DW'($urandom);
      ref_rf[a] = pre_wd;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 1, 3, -1, 0, 1'b0, '0, '0, 1'b1);          // plain dump 1..3
    run_op(1'b0, 1, 3, -1, 2, 1'b0, '0, '0, 1'b1);          // backpressure on beat 2
    run_op(1'b1, 0, 2, -1, 0, 1'b0, 32'hAAAA, 32'h1111, 1'b1); // load incl. r0
    run_op(1'b0, 0, 2, -1, 0, 1'b0, '0, '0, 1'b1);          // r0=0, r1/r2 loaded
    run_op(1'b0, 5, 4, -1, 0, 1'b0, '0, '0, 1'b1);          // bad range
    run_op(1'b1, 8, 15, 2, 0, 1'b0, '0, '0, 1'b0);          // load with abort on 3rd word
    run_op(1'b0, 8, 11, -1, 0, 1'b0, '0, '0, 1'b1);         // r10 unchanged
    run_op(1'b0, 31, 31, -1, 0, 1'b0, '0, '0, 1'b1);        // single beat at top

    // abort coincident with a dump handshake: beat not counted
    db = done_cnt;
    exp_done.push_back(1'b1);
    bus.dout_ready = 1'b0;
    bus.start = 1'b1; bus.mode = 1'b0; bus.first_reg = AW'(1); bus.last_reg = AW'(3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int g = 0; g < 10 && !bus.dout_valid; g++) begin @(posedge clk); #1; end
    chk("abort_dump_valid_seen", 64'(bus.dout_valid), 64'd1);
    bus.abort = 1'b1; bus.dout_ready = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    wait_done(db);
    end_op(db);

    for (int i = 0; i < 12; i++) begin
      md_r = 1'($urandom_range(0, 1));
      f_r = $urandom_range(0, 31);
      l_r = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : $urandom_range(f_r, 31);
      ab_r = -1;
      if (md_r && f_r <= l_r && $urandom_range(0, 3) == 0) ab_r = $urandom_range(0, l_r - f_r);
      run_op(md_r, f_r, l_r, ab_r, 1, 1'b1, '0, '0, (ab_r < 0));
    end

    // asynchronous reset in the middle of a full dump
    for (int a = 0; a < 32; a++) exp_beat.push_back({AW'(a), ref_rf[a], (a == 31)});
    exp_done.push_back(1'b0);
    bus.dout_ready = 1'b1;
    bus.start = 1'b1; bus.mode = 1'b0; bus.first_reg = '0; bus.last_reg = AW'(31);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_reset_busy", 64'(bus.busy), 64'd0);
    chk("async_reset_dout_valid", 64'(bus.dout_valid), 64'd0);
    exp_beat.delete(); exp_wr.delete(); exp_done.delete();
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 0, 31, -1, 0, 1'b0, '0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
